// File: rtl/alu_pipe.sv
// Handshaked, registered ALU with an iterative one-bit-per-cycle rotator for RSL.
// Optional macro ALU_PIPE_CARRY_EN adds a registered ADD carry-out; otherwise carry is tied to 0.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int RW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             jump_flag,
  output logic             carry
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_XOR  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_RSL  = 3'd3;
  localparam logic [2:0] OP_MOV  = 3'd4;
  localparam logic [2:0] OP_LD   = 3'd5;
  localparam logic [2:0] OP_ST   = 3'd6;
  localparam logic [2:0] OP_BLQZ = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, HOLD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q;
  logic [RW-1:0]    cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             jump_q;
  logic [RW-1:0]    r_amt;
  logic             accept;
  logic             rot_start;
  logic [WIDTH-1:0] rot_next;
  logic [WIDTH-1:0] res;
  logic             res_jump;

  // Handshake: a transfer happens on any rising edge where valid && ready are both high;
  // valid never waits on ready, and the result stays stable in HOLD until out_ready.
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign r_amt     = input2[RW-1:0];
  assign rot_start = accept && (alu_op == OP_RSL) && (r_amt != '0);
  assign rot_next  = {shadow_q[WIDTH-2:0], shadow_q[WIDTH-1]};
  assign out_valid = (state_q == HOLD);
  assign out       = out_q;
  assign jump_flag = jump_q;

  always_comb begin
    res      = '0;
    res_jump = 1'b0;
    case (alu_op)
      OP_ADD:  res = input1 + input2;
      OP_XOR:  res = input1 ^ input2;
      OP_AND:  res = input1 & input2;
      OP_RSL:  res = input1;  // only reached for a zero rotate amount
      OP_MOV,
      OP_LD:   res = input2;
      OP_ST:   res = input1;
      OP_BLQZ: res_jump = input1[WIDTH-1] | (input1 == '0);
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept)                        state_d = rot_start ? ROT : HOLD;
        else if ((state_q == HOLD) && out_ready) state_d = IDLE;
      end
      ROT:     if (cnt_q == RW'(1)) state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      jump_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        jump_q <= res_jump;
        if (rot_start) begin
          shadow_q <= input1;
          cnt_q    <= r_amt;
        end else begin
          out_q <= res;
        end
      end else if (state_q == ROT) begin
        shadow_q <= rot_next;
        cnt_q    <= cnt_q - RW'(1);
        if (cnt_q == RW'(1)) out_q <= rot_next;
      end
    end
  end

`ifdef ALU_PIPE_CARRY_EN
  logic [WIDTH:0] add_ext;
  logic           carry_q;

  assign add_ext = {1'b0, input1} + {1'b0, input2};
  assign carry   = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      carry_q <= 1'b0;
    else if (accept) carry_q <= (alu_op == OP_ADD) && add_ext[WIDTH];
  end
`else
  assign carry = 1'b0;
`endif

endmodule
